// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: EX forwarding, load-use stalls, branch flushes,
// data-memory wait freeze with a timeout FSM, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int RA_W        = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  ra1D,
  input  logic [RA_W-1:0]  ra2D,
  input  logic [RA_W-1:0]  ra1E,
  input  logic [RA_W-1:0]  ra2E,
  input  logic [RA_W-1:0]  wa3E,
  input  logic             memToRegE,
  input  logic             PCSrcE,
  input  logic [RA_W-1:0]  wa3M,
  input  logic             regWriteM,
  input  logic             memReqM,
  input  logic             memReadyM,
  input  logic [RA_W-1:0]  wa3W,
  input  logic             regWriteW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCnt
);

  localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t          state;
  logic [WC_W-1:0] waitCnt;
  logic            memStall;
  logic            loadUse;

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] ra);
    if (regWriteM && (wa3M == ra))      return 2'b10;
    else if (regWriteW && (wa3W == ra)) return 2'b01;
    else                                return 2'b00;
  endfunction

  assign memStall = (memReqM && !memReadyM) || (state == ERR);
  assign loadUse  = memToRegE && ((wa3E == ra1D) || (wa3E == ra2D));

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushW    = 1'b0;
    if (!rst) begin
      forwardAE = fwd_sel(ra1E);
      forwardBE = fwd_sel(ra2E);
      // Memory freeze wins; a branch held in E by the freeze flushes once it lifts.
      if (memStall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (PCSrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (loadUse) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      waitCnt  <= '0;
      memErr   <= 1'b0;
      stallCnt <= '0;
    end else begin
      if (stallF && (stallCnt != {CNT_W{1'b1}}))
        stallCnt <= stallCnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (memReqM && !memReadyM) begin
            state   <= WAIT;
            waitCnt <= WC_W'(1);
          end
        end
        WAIT: begin
          if (!memReqM || memReadyM) begin
            state   <= IDLE;
            waitCnt <= '0;
          end else if (waitCnt == WC_W'(MEM_TIMEOUT)) begin
            state  <= ERR;
            memErr <= 1'b1;
          end else begin
            waitCnt <= waitCnt + WC_W'(1);
          end
        end
        ERR:     memErr <= 1'b1;
        default: state  <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int RA_W = 4;
  localparam int TO   = 15;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [RA_W-1:0] ra1D, ra2D, ra1E, ra2E, wa3E, wa3M, wa3W;
  logic            memToRegE, PCSrcE, regWriteM, memReqM, memReadyM, regWriteW;
  logic [1:0]      forwardAE, forwardBE;
  logic            stallF, stallD, stallE, stallM, flushD, flushE, flushW, memErr;
  logic [CW-1:0]   stallCnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: run length of unfinished memory requests, sticky error, stall tally.
  int       streak = 0;
  bit       m_err  = 1'b0;
  int       m_cnt  = 0;
  bit [6:0] e_ctrl;

  pipeline_hazard_ctrl #(.RA_W(RA_W), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ra1D(ra1D), .ra2D(ra2D), .ra1E(ra1E), .ra2E(ra2E), .wa3E(wa3E),
    .memToRegE(memToRegE), .PCSrcE(PCSrcE),
    .wa3M(wa3M), .regWriteM(regWriteM), .memReqM(memReqM), .memReadyM(memReadyM),
    .wa3W(wa3W), .regWriteW(regWriteW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .memErr(memErr), .stallCnt(stallCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [RA_W-1:0] ra);
    logic [1:0] r;
    r = 2'b00;
    if (regWriteW && wa3W == ra) r = 2'b01;
    if (regWriteM && wa3M == ra) r = 2'b10;
    return r;
  endfunction

  task automatic clear_in();
    {ra1D, ra2D, ra1E, ra2E, wa3E, wa3M, wa3W} = '0;
    {memToRegE, PCSrcE, regWriteM, memReqM, memReadyM, regWriteW} = '0;
  endtask

  // Let inputs settle and compare every output against the model.
  task automatic settle();
    logic [1:0] efa, efb;
    #1;
    efa = m_fwd(ra1E);
    efb = m_fwd(ra2E);
    if (rst) begin
      e_ctrl = '0; efa = 2'b00; efb = 2'b00;
    end else if ((memReqM && !memReadyM) || m_err)
      e_ctrl = 7'b1111001;
    else if (PCSrcE)
      e_ctrl = 7'b0000110;
    else if (memToRegE && (wa3E == ra1D || wa3E == ra2D))
      e_ctrl = 7'b1100010;
    else
      e_ctrl = 7'b0000000;
    check("forwardAE", forwardAE, efa);
    check("forwardBE", forwardBE, efb);
    check("stall_flush", {stallF, stallD, stallE, stallM, flushD, flushE, flushW}, e_ctrl);
    check("memErr", memErr, rst ? 1'b0 : m_err);
    check("stallCnt", stallCnt, rst ? 0 : m_cnt);
  endtask

  // Advance the model to the coming rising edge, then move to the next falling edge.
  task automatic adv();
    if (rst) begin
      streak = 0; m_err = 1'b0; m_cnt = 0;
    end else begin
      if (e_ctrl[6] && m_cnt < CMAX) m_cnt++;
      if (!m_err) begin
        if (memReqM && !memReadyM) begin
          streak++;
          if (streak > TO) m_err = 1'b1;
        end else begin
          streak = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; settle(); adv(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    memReqM = 1'b1;
    PCSrcE  = 1'b1;
    settle();
    check("reset_outputs", {forwardAE, forwardBE, stallF, stallD, stallE, stallM,
                            flushD, flushE, flushW, memErr, stallCnt}, 0);
    adv();
    rst = 1'b0;
    clear_in();

    // Forwarding: M beats W, then W alone.
    ra1E = 4'd3; wa3M = 4'd3; regWriteM = 1'b1; wa3W = 4'd3; regWriteW = 1'b1;
    settle(); check("fwd_M_priority", forwardAE, 2'b10); adv();
    regWriteM = 1'b0;
    settle(); check("fwd_W", forwardAE, 2'b01); adv();
    clear_in();

    // Load-use stall for one cycle.
    memToRegE = 1'b1; wa3E = 4'd5; ra2D = 4'd5;
    settle(); check("loaduse_bits", {stallF, stallD, flushE, stallE}, 4'b1110); adv();
    clear_in();
    settle(); check("loaduse_cnt", stallCnt, 1); adv();

    // Three-cycle memory wait.
    pulse_reset();
    memReqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle(); check("memwait_stall", {stallF, stallD, stallE, stallM, flushW}, 5'b11111); adv();
    end
    memReadyM = 1'b1;
    settle(); check("memwait_release", stallF, 1'b0); adv();
    clear_in();
    settle(); check("memwait_cnt", stallCnt, 3); check("memwait_noerr", memErr, 1'b0); adv();

    // Branch held behind a memory wait flushes on release.
    memReqM = 1'b1; PCSrcE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle(); check("branch_held", {flushD, flushE}, 2'b00); adv();
    end
    memReadyM = 1'b1;
    settle(); check("branch_release", {flushD, flushE, stallF}, 3'b110); adv();
    clear_in();

    // Timeout into error, counter saturation, reset out of error.
    pulse_reset();
    memReqM = 1'b1;
    for (int i = 0; i < 16; i++) begin
      settle(); check("timeout_pre", memErr, 1'b0); adv();
    end
    settle(); check("timeout_err", {memErr, stallF}, 2'b11); adv();
    for (int i = 0; i < 4; i++) begin settle(); adv(); end
    memReqM = 1'b0;
    settle(); check("err_absorb_stall", stallF, 1'b1); check("cnt_saturate", stallCnt, 15); adv();
    rst = 1'b1;
    settle();
    check("reset_mid_err", {stallF, stallD, stallE, stallM, flushD, flushE, flushW,
                            memErr, stallCnt}, 0);
    adv();
    rst = 1'b0;
    settle(); check("post_reset_err", {memErr, stallF}, 2'b00); adv();

    // Randomized traffic in phases: mixed, slow memory, fast memory.
    for (int c = 0; c < 3000; c++) begin
      int mode;
      mode = (c / 250) % 3;
      ra1D = RA_W'($urandom_range(0, 3)); ra2D = RA_W'($urandom_range(0, 3));
      ra1E = RA_W'($urandom_range(0, 3)); ra2E = RA_W'($urandom_range(0, 3));
      wa3E = RA_W'($urandom_range(0, 3)); wa3M = RA_W'($urandom_range(0, 3));
      wa3W = RA_W'($urandom_range(0, 3));
      regWriteM = 1'($urandom_range(0, 1));
      regWriteW = 1'($urandom_range(0, 1));
      memToRegE = 1'($urandom_range(0, 1));
      PCSrcE    = ($urandom_range(0, 3) == 0);
      case (mode)
        0:       begin memReqM = 1'($urandom_range(0, 1)); memReadyM = 1'($urandom_range(0, 1)); end
        1:       begin memReqM = ($urandom_range(0, 19) != 0); memReadyM = ($urandom_range(0, 9) == 0); end
        default: begin memReqM = 1'($urandom_range(0, 1)); memReadyM = 1'b1; end
      endcase
      rst = ($urandom_range(0, 199) == 0);
      settle();
      adv();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
